// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC init sequencer: FSM states, error codes,
// table entry layout and the bus write-word formatter.
package adc_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SETTLE,
        ST_POLL,
        ST_CHECK,
        ST_NEXT,
        ST_FINISH,
        ST_FAIL
    } state_e;

    localparam int TBL_DEPTH = 16;
    localparam int TBL_AW    = 4;
    localparam int ENTRY_W   = 26;
    localparam int DATA_W    = 24;
    localparam int SEL1_BIT  = 24;
    localparam int SEL2_BIT  = 25;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;

    // Bus write word: upper half zero, selects in [31:30], config word in [23:0].
    function automatic logic [63:0] cfg_word(input logic [ENTRY_W-1:0] e);
        return {32'b0, e[SEL2_BIT], e[SEL1_BIT], 6'b0, e[DATA_W-1:0]};
    endfunction

endpackage

// File: rtl/adc_init_table.sv
// 16-entry init table: one synchronous write port, one combinational read port.
// Deliberately has no reset so contents survive a sequencer reset.
module adc_init_table
    import adc_cfg_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [TBL_AW-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [TBL_AW-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_q [TBL_DEPTH];

    // Store an entry on a qualified write strobe.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/adc_init_sequencer.sv
// Walks the init table, writing each selected entry to the ADC config bus,
// then polls status until the ADC is idle and the readback matches.
module adc_init_sequencer
    import adc_cfg_pkg::*;
#(
    parameter int TIMEOUT = 4095,
    parameter int SETTLE  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TBL_WE,
    input  logic [3:0]  TBL_ADDR,
    input  logic [25:0] TBL_DATA,
    input  logic [4:0]  NUM_ENTRIES,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [1:0]  ERR_CODE,
    output logic [3:0]  CUR_INDEX,
    output logic        CFG_CEb,
    output logic        CFG_WEb,
    output logic        CFG_OEb,
    output logic [63:0] CFG_DOUT,
    output logic        CFG_DOUT_EN,
    input  logic [63:0] CFG_DIN
);

    localparam int PW = $clog2(TIMEOUT + 1);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [4:0]         num_q, num_d;
    logic [PW-1:0]      poll_cnt_q, poll_cnt_d;
    logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
    logic [31:0]        din_q, din_d;
    logic               error_q, error_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [ENTRY_W-1:0] entry;
    logic [PW-1:0]      poll_inc;
    logic               last_settle;
    logic               unused_din;

    adc_init_table u_table (
        .clk   (CLK),
        .we    (TBL_WE && (state_q == ST_IDLE)),
        .waddr (TBL_ADDR),
        .wdata (TBL_DATA),
        .raddr (idx_q),
        .rdata (entry)
    );

    assign poll_inc    = poll_cnt_q + 1'b1;
    // SETTLE of 0 or 1 both give a single idle cycle between bus cycles.
    assign last_settle = (SETTLE <= 1) || (settle_cnt_q == SW'(SETTLE - 1));
    assign unused_din  = ^{CFG_DIN[63:32], din_q[29:24]};

    // State and datapath registers; reset aborts any sequence immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            num_q        <= '0;
            poll_cnt_q   <= '0;
            settle_cnt_q <= '0;
            din_q        <= '0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            poll_cnt_q   <= poll_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            din_q        <= din_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    // Next-state logic and bus strobes, decoded from the current state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        num_d        = num_q;
        poll_cnt_d   = poll_cnt_q;
        settle_cnt_d = settle_cnt_q;
        din_d        = din_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        CFG_CEb      = 1'b1;
        CFG_WEb      = 1'b1;
        CFG_OEb      = 1'b1;
        CFG_DOUT_EN  = 1'b0;
        CFG_DOUT     = '0;
        DONE         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    idx_d      = '0;
                    poll_cnt_d = '0;
                    // Latch the clamped count so the run is immune to input changes.
                    num_d      = (NUM_ENTRIES > 5'd16) ? 5'd16 : NUM_ENTRIES;
                    state_d    = (NUM_ENTRIES == 5'd0) ? ST_FINISH : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (entry[SEL2_BIT:SEL1_BIT] == 2'b00) begin
                    state_d = ST_NEXT;
                end else begin
                    CFG_CEb      = 1'b0;
                    CFG_WEb      = 1'b0;
                    CFG_DOUT_EN  = 1'b1;
                    CFG_DOUT     = cfg_word(entry);
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (last_settle) state_d = ST_POLL;
                else             settle_cnt_d = settle_cnt_q + 1'b1;
            end
            ST_POLL: begin
                CFG_CEb = 1'b0;
                CFG_OEb = 1'b0;
                din_d   = CFG_DIN[31:0];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (din_q[31:30] != 2'b00) begin
                    poll_cnt_d = poll_inc;
                    if (poll_inc == PW'(TIMEOUT)) begin
                        state_d = ST_FAIL;
                    end else begin
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end
                end else if (din_q[23:0] != entry[DATA_W-1:0]) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                poll_cnt_d = '0;
                if ({1'b0, idx_q} == num_q - 5'd1) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_WRITE;
                end
            end
            ST_FINISH: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                // The failing poll is still in din_q, so it tells which check tripped.
                error_d    = 1'b1;
                err_code_d = (din_q[31:30] != 2'b00) ? ERR_TIMEOUT : ERR_MISMATCH;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign ERROR     = error_q;
    assign ERR_CODE  = err_code_q;
    assign CUR_INDEX = idx_q;

endmodule

// File: tb/tb_adc_init_sequencer.sv
// Randomized and directed bench for adc_init_sequencer with a behavioural ADC.
module tb_adc_init_sequencer;

    localparam int TO = 8;
    localparam int ST = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        TBL_WE = 1'b0;
    logic [3:0]  TBL_ADDR = '0;
    logic [25:0] TBL_DATA = '0;
    logic [4:0]  NUM_ENTRIES = '0;
    logic        START = 1'b0;
    logic        BUSY, DONE, ERROR;
    logic [1:0]  ERR_CODE;
    logic [3:0]  CUR_INDEX;
    logic        CFG_CEb, CFG_WEb, CFG_OEb, CFG_DOUT_EN;
    logic [63:0] CFG_DOUT, CFG_DIN;

    always #5 CLK = ~CLK;

    adc_init_sequencer #(.TIMEOUT(TO), .SETTLE(ST)) dut (
        .CLK(CLK), .RST(RST), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
        .NUM_ENTRIES(NUM_ENTRIES), .START(START), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .ERR_CODE(ERR_CODE), .CUR_INDEX(CUR_INDEX), .CFG_CEb(CFG_CEb), .CFG_WEb(CFG_WEb),
        .CFG_OEb(CFG_OEb), .CFG_DOUT(CFG_DOUT), .CFG_DOUT_EN(CFG_DOUT_EN), .CFG_DIN(CFG_DIN)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural ADC ----------------
    int          busy_polls = 0;   // busy status returned for this many polls after a write
    bit          stuck = 0;        // never leaves busy
    bit          bad_rb = 0;       // reads back zero instead of the written word
    int          busy_left = 0;
    logic [23:0] rb = '0;
    logic [63:0] wr_log[$];
    int          poll_n = 0, done_n = 0, proto_bad = 0;

    always_comb CFG_DIN = {32'hDEAD_BEEF, (stuck || busy_left > 0) ? 2'b10 : 2'b00, 6'h2A, rb};

    always @(posedge CLK) begin
        if (!CFG_CEb && !CFG_WEb) begin
            wr_log.push_back(CFG_DOUT);
            busy_left <= busy_polls;
            rb <= bad_rb ? 24'h0 : CFG_DOUT[23:0];
        end
        if (!CFG_CEb && !CFG_OEb) begin
            poll_n++;
            if (busy_left > 0) busy_left <= busy_left - 1;
        end
        if (DONE) done_n++;
        if ((!CFG_WEb && !CFG_OEb) || (CFG_WEb && CFG_OEb && !CFG_CEb) ||
            (CFG_DOUT_EN != (!CFG_CEb && !CFG_WEb)))
            proto_bad++;
    end

    // ---------------- reference model ----------------
    logic [25:0] tbl_m[16];
    logic [63:0] ex_wr[$];
    int          ex_polls, ex_idx;
    logic        ex_err;
    logic [1:0]  ex_code;

    function automatic void predict(input int num);
        int n;
        n = (num > 16) ? 16 : num;
        ex_wr.delete();
        ex_polls = 0; ex_err = 0; ex_code = 2'b00;
        ex_idx = (n == 0) ? 0 : n - 1;
        for (int i = 0; i < n; i++) begin
            if (tbl_m[i][25:24] == 2'b00) continue;
            ex_wr.push_back({32'h0, tbl_m[i][25:24], 6'h0, tbl_m[i][23:0]});
            if (stuck) begin
                ex_polls += TO; ex_err = 1; ex_code = 2'b01; ex_idx = i;
                break;
            end
            ex_polls += busy_polls + 1;
            if (bad_rb && tbl_m[i][23:0] != 24'h0) begin
                ex_err = 1; ex_code = 2'b10; ex_idx = i;
                break;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic tbl_wr(input int a, input logic [25:0] d, input bit upd);
        TBL_WE = 1'b1; TBL_ADDR = a[3:0]; TBL_DATA = d;
        tick();
        TBL_WE = 1'b0;
        if (upd) tbl_m[a] = d;
    endtask

    task automatic start(input int num);
        NUM_ENTRIES = 5'(num); START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (BUSY && k < 3000) begin tick(); k++; end
        chk({tag, "_idle"}, 64'(BUSY), 64'd0);
    endtask

    task automatic run(input string tag, input int num, input bit poke);
        int p0, d0;
        predict(num);
        wr_log.delete();
        p0 = poll_n; d0 = done_n;
        start(num);
        chk({tag, "_errclr"}, 64'(ERROR), 64'd0);
        if (poke && BUSY) tbl_wr(1, ~tbl_m[1], 0);
        wait_idle(tag);
        chk({tag, "_wr_n"}, 64'(wr_log.size()), 64'(ex_wr.size()));
        for (int i = 0; i < wr_log.size() && i < ex_wr.size(); i++)
            chk({tag, "_wr"}, wr_log[i], ex_wr[i]);
        chk({tag, "_polls"}, 64'(poll_n - p0), 64'(ex_polls));
        chk({tag, "_done"}, 64'(done_n - d0), ex_err ? 64'd0 : 64'd1);
        chk({tag, "_error"}, 64'(ERROR), 64'(ex_err));
        chk({tag, "_code"}, 64'(ERR_CODE), 64'(ex_code));
        chk({tag, "_idx"}, 64'(CUR_INDEX), 64'(ex_idx));
        chk({tag, "_proto"}, 64'(proto_bad), 64'd0);
    endtask

    initial begin
        int k, p0, d0;
        for (int i = 0; i < 16; i++) tbl_m[i] = '0;

        // reset state
        tick(); tick();
        chk("rst_busy", 64'(BUSY), 0);
        chk("rst_done", 64'(DONE), 0);
        chk("rst_error", 64'(ERROR), 0);
        chk("rst_code", 64'(ERR_CODE), 0);
        chk("rst_idx", 64'(CUR_INDEX), 0);
        chk("rst_strobes", 64'({CFG_CEb, CFG_WEb, CFG_OEb}), 64'h7);
        chk("rst_dout_en", 64'(CFG_DOUT_EN), 0);
        chk("rst_dout", CFG_DOUT, 0);
        RST = 1'b0;
        for (int i = 0; i < 16; i++) tbl_wr(i, 26'h0, 1);

        // single entry, ADC busy for a while, then idle with correct readback
        tbl_wr(0, {2'b01, 24'h123456}, 1);
        busy_polls = 6;
        run("single", 1, 0);
        chk("single_word", wr_log.size() > 0 ? wr_log[0] : 64'hX, 64'h0000_0000_4012_3456);

        // skipped middle entry
        busy_polls = 1;
        tbl_wr(0, {2'b10, 24'h00A001}, 1);
        tbl_wr(1, {2'b00, 24'h00B002}, 1);
        tbl_wr(2, {2'b11, 24'h00C003}, 1);
        run("skip", 3, 0);

        // ADC never leaves busy
        stuck = 1;
        run("timeout", 1, 0);
        stuck = 0;

        // bad readback, then a clean rerun clears the error
        tbl_wr(0, {2'b01, 24'hABCDEF}, 1);
        bad_rb = 1; busy_polls = 0;
        run("mismatch", 1, 0);
        bad_rb = 0;
        run("recover", 1, 0);

        // zero entries: immediate DONE, no bus traffic
        wr_log.delete(); p0 = poll_n; d0 = done_n;
        start(0);
        chk("num0_done_now", 64'(DONE), 1);
        wait_idle("num0");
        chk("num0_done_n", 64'(done_n - d0), 1);
        chk("num0_bus", 64'(wr_log.size() + poll_n - p0), 0);

        // table writes during a run are ignored
        run("poke", 3, 1);
        run("after_poke", 3, 0);

        // reset during SETTLE of entry 2
        for (int i = 0; i < 4; i++) tbl_wr(i, {2'(i % 3 + 1), 24'($urandom)}, 1);
        busy_polls = 0;
        wr_log.delete();
        start(4);
        k = 0;
        while (wr_log.size() < 3 && k < 500) begin tick(); k++; end
        chk("rst_mid_reach", 64'(wr_log.size()), 3);
        p0 = poll_n;
        RST = 1'b1;
        tick();
        chk("rst_mid_strobes", 64'({CFG_CEb, CFG_WEb, CFG_OEb, CFG_DOUT_EN}), 64'hE);
        chk("rst_mid_busy", 64'(BUSY), 0);
        RST = 1'b0;
        tick(); tick(); tick();
        chk("rst_mid_nobus", 64'(poll_n - p0 + wr_log.size()), 3);
        run("rerun", 4, 0);

        // randomized tables, counts and ADC behaviours
        for (int it = 0; it < 10; it++) begin
            int r;
            for (int a = 0; a < 16; a++)
                tbl_wr(a, {2'($urandom_range(0, 3)), 24'($urandom)}, 1);
            r = $urandom_range(0, 9);
            stuck = (r == 0);
            bad_rb = (r == 1);
            busy_polls = $urandom_range(0, 4);
            run($sformatf("rand%0d", it), $urandom_range(0, 20), 0);
        end
        stuck = 0; bad_rb = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_init_sequencer.md
ADC_INIT_SEQUENCER -- requirements
Module: adc_init_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 4095: maximum busy polls per entry before timeout.
REQ-002 Parameter SETTLE, default 2: idle CLK cycles between write and first poll, and between polls.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 TBL_WE  in  1  table write strobe; accepted only when BUSY=0.
REQ-006 TBL_ADDR  in  4  table entry index.
REQ-007 TBL_DATA  in  26  table entry: [25]=ADC2 select, [24]=ADC1 select, [23:0]=config word.
REQ-008 NUM_ENTRIES  in  5  entries to run; values >16 are clamped to 16.
REQ-009 START  in  1  one-cycle run request.
REQ-010 BUSY  out  1  sequence in progress.
REQ-011 DONE  out  1  one-cycle pulse at successful completion.
REQ-012 ERROR  out  1  sticky failure flag, cleared by accepted START or RST.
REQ-013 ERR_CODE  out  2  01=poll timeout, 10=readback mismatch, 00=none.
REQ-014 CUR_INDEX  out  4  entry being processed, or entry that failed.
REQ-015 CFG_CEb, CFG_WEb, CFG_OEb  out  1 each  active-low strobes to the ADC config register bus.
REQ-016 CFG_DOUT  out  64  write data; CFG_DOUT_EN  out  1  high only during the write cycle; the top level builds the tri-state.
REQ-017 CFG_DIN  in  64  bus read data, valid combinationally while CFG_CEb=0 and CFG_OEb=0.

Function
REQ-018 The block SHALL hold a 16x26 register table written on TBL_WE when BUSY=0; table writes during BUSY SHALL be ignored.
REQ-019 The FSM states SHALL be IDLE, WRITE, SETTLE, POLL, CHECK, NEXT, FINISH, FAIL.
REQ-020 IDLE: START with NUM_ENTRIES=0 SHALL go to FINISH; START with NUM_ENTRIES>0 SHALL set index 0, clear ERROR/ERR_CODE and go to WRITE; START while BUSY SHALL be ignored.
REQ-021 WRITE: if both select bits of the entry are 0, the block SHALL skip to NEXT without a bus cycle.
REQ-022 WRITE: otherwise, for exactly one cycle, it SHALL drive CFG_CEb=0, CFG_WEb=0, CFG_DOUT_EN=1, and CFG_DOUT={32'b0, sel2, sel1, 6'b0, data}, then go to SETTLE.
REQ-023 SETTLE SHALL hold all strobes high for SETTLE cycles, then go to POLL.
REQ-024 POLL SHALL drive CFG_CEb=0 and CFG_OEb=0 for one cycle and register CFG_DIN[31:0] at the end of that cycle; CHECK follows.
REQ-025 CHECK: if DIN[31:30]!=0, the poll counter SHALL increment; on reaching TIMEOUT, the FSM SHALL go to FAIL with code 01, otherwise return to SETTLE.
REQ-026 CHECK: if DIN[31:30]=0 and DIN[23:0]!=data, the FSM SHALL go to FAIL with code 10; if they match, it SHALL go to NEXT.
REQ-027 NEXT SHALL clear the poll counter; if index = clamped NUM_ENTRIES-1, it SHALL go to FINISH, else increment the index and go to WRITE.
REQ-028 FINISH SHALL pulse DONE for one cycle and return to IDLE.
REQ-029 FAIL SHALL set ERROR, latch ERR_CODE, freeze CUR_INDEX, and return to IDLE without a DONE pulse.
REQ-030 BUSY SHALL be 1 in all states except IDLE.
REQ-031 At most one of WEb/OEb SHALL be low in any cycle, and CFG_CEb SHALL be high whenever both are high.

Reset
REQ-032 On RST, the FSM SHALL go to IDLE; BUSY, DONE, ERROR=0; ERR_CODE=00; CUR_INDEX=0; counters=0; CFG_CEb/WEb/OEb=1; CFG_DOUT_EN=0; CFG_DOUT=0.
REQ-033 RST mid-sequence SHALL abort immediately, with no further bus cycle.
REQ-034 Table contents SHALL NOT be cleared by RST.

Structure
REQ-035 State encodings, the ERR_CODE values, and the entry field positions SHALL live in the shared package adc_cfg_pkg.
REQ-036 One sub-module, adc_init_table (16x26 register file with one write port and one read port), is natural; everything else stays flat.

Verification
REQ-037 Table[0]={01,0x123456}, NUM=1, START; model clears busy after 30 cycles -> one write of 0x0000_0000_4012_3456, polls until idle, one DONE pulse, ERROR=0.
REQ-038 NUM=3 with entry1 select=00 -> exactly two write cycles, for entries 0 and 2; DONE once.
REQ-039 Model never clears busy, TIMEOUT=8 -> eight polls, then ERROR=1, ERR_CODE=01, CUR_INDEX=0, no DONE.
REQ-040 Model reads back 0x000000 for data 0xABCDEF -> ERR_CODE=10; a following START clears ERROR.
REQ-041 RST asserted during SETTLE of entry 2 -> next cycle all strobes are high, BUSY=0, and the table is still intact for a rerun.
REQ-042 NUM_ENTRIES=0 with START -> DONE pulse within 2 cycles and no bus activity; TBL_WE while BUSY -> table unchanged.
